mem_port_arbiter: RTL

Clocked arbiter that shares the single memory port between the instruction-fetch path (program counter / address mux) and the cache. Each requester uses a four-phase req/ack handshake. Memory-side transfers use the dual-rail read_Nwrite encoding with return-to-null between transfers. Grants alternate round-robin when both requesters are pending. The block sits between the requesters and the memory, replacing the separate RW mux and address mux.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals shared by the memory-port arbiter.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_ack;
    logic [DW-1:0] f_rdata;

    logic          c_req;
    logic [1:0]    c_rw;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_ack;
    logic [DW-1:0] c_rdata;

    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [1:0]    m_rw;
    logic [DW-1:0] m_rdata;
    logic          m_ack_read;
    logic          m_ack_write;

    logic [1:0]    grant;
    logic          err;
    logic          busy;

    modport slave (
        input  f_req, f_addr, c_req, c_rw, c_addr, c_wdata,
        input  m_rdata, m_ack_read, m_ack_write,
        output f_ack, f_rdata, c_ack, c_rdata,
        output m_addr, m_wdata, m_rw, grant, err, busy
    );

    modport master (
        output f_req, f_addr, c_req, c_rw, c_addr, c_wdata,
        output m_rdata, m_ack_read, m_ack_write,
        input  f_ack, f_rdata, c_ack, c_rdata,
        input  m_addr, m_wdata, m_rw, grant, err, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and the cache.
// Requesters use four-phase req/ack; the memory side uses dual-rail read_Nwrite with
// return-to-null between transfers. All asynchronous handshake inputs are synchronized.
module mem_port_arbiter #(
    parameter int AW          = 8,
    parameter int DW          = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [1:0] RW_NULL  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b10;
    localparam logic [1:0] RW_WRITE = 2'b01;
    localparam logic [1:0] RW_ILL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE
    } state_t;

    // Synchronizer chain: bit 0 f_req, 1 c_req, 2 m_ack_read, 3 m_ack_write
    logic [3:0] sync_q [NS];
    logic [3:0] sync_d [NS];

    logic f_req_s;
    logic c_req_s;
    logic ack_r_s;
    logic ack_w_s;

    state_t        state_q,      state_d;
    logic          last_cache_q, last_cache_d;
    logic [1:0]    grant_q,      grant_d;
    logic [1:0]    m_rw_q,       m_rw_d;
    logic [AW-1:0] m_addr_q,     m_addr_d;
    logic [DW-1:0] m_wdata_q,    m_wdata_d;
    logic          f_ack_q,      f_ack_d;
    logic          c_ack_q,      c_ack_d;
    logic [DW-1:0] f_rdata_q,    f_rdata_d;
    logic [DW-1:0] c_rdata_q,    c_rdata_d;
    logic          err_q,        err_d;

    logic c_legal;
    logic c_elig;
    logic pick_cache;
    logic exp_ack;
    logic grantee_req;

    assign f_req_s = sync_q[NS-1][0];
    assign c_req_s = sync_q[NS-1][1];
    assign ack_r_s = sync_q[NS-1][2];
    assign ack_w_s = sync_q[NS-1][3];

    assign c_legal     = (bus.c_rw == RW_READ) || (bus.c_rw == RW_WRITE);
    assign c_elig      = c_req_s && c_legal;
    assign pick_cache  = c_elig && (!f_req_s || !last_cache_q);
    assign exp_ack     = (m_rw_q == RW_READ) ? ack_r_s : ack_w_s;
    assign grantee_req = grant_q[0] ? f_req_s : c_req_s;

    // Shift raw handshake inputs one stage per clock toward the synchronized output
    always_comb begin
        sync_d[0] = {bus.m_ack_write, bus.m_ack_read, bus.c_req, bus.f_req};
        for (int i = 1; i < NS; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchronizer flops, cleared by reset so stale handshakes are forgotten
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NS; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    // Next-state logic: grant in IDLE, wait for the matching memory ack in ISSUE,
    // wait for the full return-to-null of both sides in RELEASE
    always_comb begin
        state_d      = state_q;
        last_cache_d = last_cache_q;
        grant_d      = grant_q;
        m_rw_d       = m_rw_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        f_ack_d      = f_ack_q;
        c_ack_d      = c_ack_q;
        f_rdata_d    = f_rdata_q;
        c_rdata_d    = c_rdata_q;
        err_d        = err_q;

        case (state_q)
            IDLE: begin
                if (c_req_s && (bus.c_rw == RW_ILL)) begin
                    err_d = 1'b1;
                end
                if (f_req_s || c_elig) begin
                    state_d = ISSUE;
                    if (pick_cache) begin
                        grant_d   = 2'b10;
                        m_rw_d    = bus.c_rw;
                        m_addr_d  = bus.c_addr;
                        m_wdata_d = bus.c_wdata;
                    end else begin
                        grant_d  = 2'b01;
                        m_rw_d   = RW_READ;
                        m_addr_d = bus.f_addr;
                    end
                end
            end
            ISSUE: begin
                if (exp_ack) begin
                    if (m_rw_q == RW_READ) begin
                        if (grant_q[0]) begin
                            f_rdata_d = bus.m_rdata;
                        end else begin
                            c_rdata_d = bus.m_rdata;
                        end
                    end
                    if (grant_q[0]) begin
                        f_ack_d = 1'b1;
                    end else begin
                        c_ack_d = 1'b1;
                    end
                    m_rw_d  = RW_NULL;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_r_s && !ack_w_s && !grantee_req) begin
                    f_ack_d      = 1'b0;
                    c_ack_d      = 1'b0;
                    grant_d      = 2'b00;
                    last_cache_d = grant_q[1];
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state and registered outputs; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_cache_q <= 1'b1;
            grant_q      <= 2'b00;
            m_rw_q       <= RW_NULL;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            f_ack_q      <= 1'b0;
            c_ack_q      <= 1'b0;
            f_rdata_q    <= '0;
            c_rdata_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_cache_q <= last_cache_d;
            grant_q      <= grant_d;
            m_rw_q       <= m_rw_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            f_ack_q      <= f_ack_d;
            c_ack_q      <= c_ack_d;
            f_rdata_q    <= f_rdata_d;
            c_rdata_q    <= c_rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.f_ack   = f_ack_q;
    assign bus.c_ack   = c_ack_q;
    assign bus.f_rdata = f_rdata_q;
    assign bus.c_rdata = c_rdata_q;
    assign bus.m_rw    = m_rw_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.grant   = grant_q;
    assign bus.err     = err_q;
    assign bus.busy    = (state_q != IDLE);

endmodule
